// File: rtl/fb_pkg.sv
// Shared framebuffer constants, fill FSM states, and the y*320+x address helper.
package fb_pkg;
    localparam int H_RES   = 320;
    localparam int V_RES   = 240;
    localparam int ADDR_W  = 17;
    localparam int COLOR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

    // 320 = 256 + 64, so the row offset is two shifted copies of y
    function automatic logic [ADDR_W-1:0] fb_xy_to_addr(input logic [8:0] x, input logic [7:0] y);
        logic [ADDR_W-1:0] y_ext;
        y_ext = {{(ADDR_W-8){1'b0}}, y};
        return (y_ext << 8) + (y_ext << 6) + {{(ADDR_W-9){1'b0}}, x};
    endfunction
endpackage

// File: rtl/fb_fill_engine.sv
// Rectangle-fill engine: captures parameters, clips to the screen, walks the
// rectangle row by row and presents one pixel write per granted cycle.
module fb_fill_engine
    import fb_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               fill_start,
    input  logic [8:0]         fill_x0,
    input  logic [7:0]         fill_y0,
    input  logic [8:0]         fill_w,
    input  logic [7:0]         fill_h,
    input  logic [COLOR_W-1:0] fill_color,
    input  logic               gnt,
    output logic               req,
    output logic [ADDR_W-1:0]  addr,
    output logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done
);
    fill_state_t        state_r, state_s;
    logic [8:0]         x0_r, w_r, cx_r;
    logic [7:0]         y0_r, h_r, cy_r;
    logic [COLOR_W-1:0] color_r;
    logic [9:0]         xe_r, ye_r, xsum_s, ysum_s, xe_s, ye_s;
    logic [ADDR_W-1:0]  row_base_r;
    logic               empty_s, last_col_s, last_row_s;

    // Clipped end coordinates and degenerate-rectangle detection
    always_comb begin
        xsum_s  = {1'b0, x0_r} + {1'b0, w_r};
        ysum_s  = {2'b00, y0_r} + {2'b00, h_r};
        xe_s    = (xsum_s > 10'(H_RES)) ? 10'(H_RES) : xsum_s;
        ye_s    = (ysum_s > 10'(V_RES)) ? 10'(V_RES) : ysum_s;
        empty_s = (w_r == 9'd0) || (h_r == 8'd0) ||
                  ({1'b0, x0_r} >= 10'(H_RES)) || ({2'b00, y0_r} >= 10'(V_RES));
        last_col_s = ({1'b0, cx_r} == (xe_r - 10'd1));
        last_row_s = ({2'b00, cy_r} == (ye_r - 10'd1));
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (fill_start) state_s = SETUP;
                else            state_s = IDLE;
            end
            SETUP: begin
                if (empty_s) state_s = DONE;
                else         state_s = FILL;
            end
            FILL: begin
                if (gnt && last_col_s && last_row_s) state_s = DONE;
                else                                  state_s = FILL;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Parameter capture and rectangle walk counters
    always_ff @(posedge clock) begin
        if (reset) begin
            x0_r       <= 9'd0;
            y0_r       <= 8'd0;
            w_r        <= 9'd0;
            h_r        <= 8'd0;
            color_r    <= '0;
            xe_r       <= 10'd0;
            ye_r       <= 10'd0;
            cx_r       <= 9'd0;
            cy_r       <= 8'd0;
            row_base_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fill_start) begin
                        x0_r    <= fill_x0;
                        y0_r    <= fill_y0;
                        w_r     <= fill_w;
                        h_r     <= fill_h;
                        color_r <= fill_color;
                    end
                end
                SETUP: begin
                    xe_r       <= xe_s;
                    ye_r       <= ye_s;
                    cx_r       <= x0_r;
                    cy_r       <= y0_r;
                    row_base_r <= fb_xy_to_addr(9'd0, y0_r);
                end
                FILL: begin
                    if (gnt) begin
                        if (last_col_s) begin
                            cx_r       <= x0_r;
                            cy_r       <= cy_r + 8'd1;
                            row_base_r <= row_base_r + ADDR_W'(H_RES);
                        end else begin
                            cx_r <= cx_r + 9'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req   = (state_r == FILL);
    assign addr  = row_base_r + {{(ADDR_W-9){1'b0}}, cx_r};
    assign color = color_r;
    assign busy  = (state_r != IDLE);
    assign done  = (state_r == DONE);
endmodule

// File: rtl/fb_write_ctrl.sv
// Framebuffer write-port controller: round-robin between CPU pixel stores and
// the fill engine, registered write port. Optional macro FB_WR_BOUNDS_CHECK_EN.
module fb_write_ctrl
    import fb_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [8:0]         pix_x,
    input  logic [7:0]         pix_y,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic               fill_start,
    input  logic [8:0]         fill_x0,
    input  logic [7:0]         fill_y0,
    input  logic [8:0]         fill_w,
    input  logic [7:0]         fill_h,
    input  logic [COLOR_W-1:0] fill_color,
    output logic               fill_busy,
    output logic               fill_done,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               oob_err
);
    logic               fill_req_s, fill_gnt_s, pix_gnt_s, pix_ready_s, pix_write_s;
    logic [ADDR_W-1:0]  fill_addr_s, pix_addr_s;
    logic [COLOR_W-1:0] fill_color_s;
    logic               last_grant_r;   // 1: fill won the last contention
    logic               wr_en_r;
    logic [ADDR_W-1:0]  wr_addr_r;
    logic [COLOR_W-1:0] wr_data_r;

    fb_fill_engine u_fill (
        .clock      (clock),
        .reset      (reset),
        .fill_start (fill_start),
        .fill_x0    (fill_x0),
        .fill_y0    (fill_y0),
        .fill_w     (fill_w),
        .fill_h     (fill_h),
        .fill_color (fill_color),
        .gnt        (fill_gnt_s),
        .req        (fill_req_s),
        .addr       (fill_addr_s),
        .color      (fill_color_s),
        .busy       (fill_busy),
        .done       (fill_done)
    );

    // Round-robin grant; only a true contention moves last_grant
    always_comb begin
        pix_gnt_s   = 1'b0;
        fill_gnt_s  = 1'b0;
        pix_ready_s = 1'b1;
        if (fill_req_s && pix_valid) begin
            pix_gnt_s   = last_grant_r;
            fill_gnt_s  = ~last_grant_r;
            pix_ready_s = last_grant_r;
        end else begin
            pix_gnt_s   = pix_valid;
            fill_gnt_s  = fill_req_s;
            pix_ready_s = 1'b1;
        end
    end

    assign pix_addr_s = fb_xy_to_addr(pix_x, pix_y);

`ifdef FB_WR_BOUNDS_CHECK_EN
    logic pix_oob_s;
    logic oob_err_r;
    assign pix_oob_s   = (pix_x >= 9'(H_RES)) || (pix_y >= 8'(V_RES));
    assign pix_write_s = pix_gnt_s & ~pix_oob_s;

    // Sticky out-of-bounds flag; an off-screen pixel still uses its grant slot
    always_ff @(posedge clock) begin
        if (reset)                       oob_err_r <= 1'b0;
        else if (pix_gnt_s && pix_oob_s) oob_err_r <= 1'b1;
        else                             oob_err_r <= oob_err_r;
    end
    assign oob_err = oob_err_r;
`else
    assign pix_write_s = pix_gnt_s;
    assign oob_err     = 1'b0;
`endif

    // Arbitration history
    always_ff @(posedge clock) begin
        if (reset)                          last_grant_r <= 1'b1;
        else if (fill_req_s && pix_valid)   last_grant_r <= fill_gnt_s;
        else                                last_grant_r <= last_grant_r;
    end

    // Registered framebuffer write port, one cycle behind the grant
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else begin
            wr_en_r <= pix_write_s | fill_gnt_s;
            if (fill_gnt_s) begin
                wr_addr_r <= fill_addr_s;
                wr_data_r <= fill_color_s;
            end else if (pix_write_s) begin
                wr_addr_r <= pix_addr_s;
                wr_data_r <= pix_color;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

    assign pix_ready = pix_ready_s;
    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed self-checking bench for fb_write_ctrl: pixel vector table plus
// hand-written fill, contention, restart and reset sequences.
module tb_fb_write_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        pix_valid, pix_ready;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic [2:0]  pix_color;
    logic        fill_start;
    logic [8:0]  fill_x0, fill_w;
    logic [7:0]  fill_y0, fill_h;
    logic [2:0]  fill_color;
    logic        fill_busy, fill_done, wr_en, oob_err;
    logic [16:0] wr_addr;
    logic [2:0]  wr_data;

    fb_write_ctrl dut (
        .clock(clock), .reset(reset),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .fill_start(fill_start), .fill_x0(fill_x0), .fill_y0(fill_y0),
        .fill_w(fill_w), .fill_h(fill_h), .fill_color(fill_color),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .oob_err(oob_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [2:0]  c;
        logic [16:0] exp_addr;
    } pix_vec_t;

    pix_vec_t    vecs[6];
    int          total = 0;
    int          passed = 0;
    logic [16:0] wa_q[$];
    logic [2:0]  wd_q[$];
    int          wi_q[$];
    int          done_at;
    logic        bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts a fill and records every write until fill_done (bounded).
    // Index 0 is the sample after the edge that captured fill_start.
    task automatic run_fill(input logic [8:0] x0, input logic [7:0] y0, input logic [8:0] w,
                            input logic [7:0] h, input logic [2:0] col, input int restart_at);
        wa_q.delete(); wd_q.delete(); wi_q.delete();
        done_at = -1;
        fill_x0 = x0; fill_y0 = y0; fill_w = w; fill_h = h; fill_color = col;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        chk("busy_in_setup", 32'(fill_busy), 32'd1);
        for (int i = 1; i <= 300; i++) begin
            if (restart_at > 0 && i - 1 == restart_at) begin
                fill_start = 1'b1;
                fill_x0 = 9'd100; fill_y0 = 8'd100; fill_w = 9'd2; fill_h = 8'd2; fill_color = 3'd6;
            end else begin
                fill_start = 1'b0;
            end
            tick();
            if (wr_en) begin
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_data);
                wi_q.push_back(i);
            end
            if (fill_done) begin
                done_at = i;
                break;
            end
        end
        fill_start = 1'b0;
        if (done_at < 0) chk("fill_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [16:0] exp_a[$];
        logic [2:0]  exp_d[$];
        int          k;

        vecs[0] = '{x: 9'd5,   y: 8'd2,   c: 3'd5, exp_addr: 17'd645};
        vecs[1] = '{x: 9'd0,   y: 8'd0,   c: 3'd0, exp_addr: 17'd0};
        vecs[2] = '{x: 9'd319, y: 8'd239, c: 3'd7, exp_addr: 17'd76799};
        vecs[3] = '{x: 9'd100, y: 8'd10,  c: 3'd3, exp_addr: 17'd3300};
        vecs[4] = '{x: 9'd1,   y: 8'd1,   c: 3'd6, exp_addr: 17'd321};
        vecs[5] = '{x: 9'd0,   y: 8'd239, c: 3'd1, exp_addr: 17'd76480};

        reset = 1'b1; pix_valid = 1'b0; pix_x = 9'd0; pix_y = 8'd0; pix_color = 3'd0;
        fill_start = 1'b0; fill_x0 = 9'd0; fill_y0 = 8'd0; fill_w = 9'd0; fill_h = 8'd0;
        fill_color = 3'd0;
        tick();
        tick();
        chk("rst_wr_en",   32'(wr_en),     32'd0);
        chk("rst_wr_addr", 32'(wr_addr),   32'd0);
        chk("rst_wr_data", 32'(wr_data),   32'd0);
        chk("rst_busy",    32'(fill_busy), 32'd0);
        chk("rst_done",    32'(fill_done), 32'd0);
        chk("rst_oob",     32'(oob_err),   32'd0);
        reset = 1'b0;
        tick();

        // Pixel table
        for (int v = 0; v < 6; v++) begin
            pix_valid = 1'b1; pix_x = vecs[v].x; pix_y = vecs[v].y; pix_color = vecs[v].c;
            #1;
            chk("pix_ready", 32'(pix_ready), 32'd1);
            tick();
            pix_valid = 1'b0;
            chk("pix_wr_en",   32'(wr_en),   32'd1);
            chk("pix_wr_addr", 32'(wr_addr), 32'(vecs[v].exp_addr));
            chk("pix_wr_data", 32'(wr_data), 32'(vecs[v].c));
            chk("pix_oob",     32'(oob_err), 32'd0);
            tick();
            chk("pix_wr_idle", 32'(wr_en), 32'd0);
        end

        // Clipped fill at the bottom-right corner: 2x2 pixels survive
        run_fill(9'd318, 8'd238, 9'd4, 8'd4, 3'd2, -1);
        chk("clip_count", 32'(wa_q.size()), 32'd4);
        exp_a = '{17'd76478, 17'd76479, 17'd76798, 17'd76799};
        for (int j = 0; j < 4 && j < wa_q.size(); j++) begin
            chk("clip_addr", 32'(wa_q[j]), 32'(exp_a[j]));
            chk("clip_data", 32'(wd_q[j]), 32'd2);
        end
        chk("clip_done_at", 32'(done_at), 32'd5);
        if (wi_q.size() > 0) chk("clip_done_with_last", 32'(wi_q[wi_q.size()-1]), 32'(done_at));
        else chk("clip_done_with_last", 32'd0, 32'(done_at));
        tick();
        chk("clip_busy_after", 32'(fill_busy), 32'd0);
        chk("clip_done_once",  32'(fill_done), 32'd0);
        chk("clip_wr_after",   32'(wr_en),     32'd0);

        // Contention: pixel held high through a 3x1 fill
        pix_valid = 1'b1; pix_x = 9'd0; pix_y = 8'd0; pix_color = 3'd7;
        run_fill(9'd10, 8'd5, 9'd3, 8'd1, 3'd2, -1);
        pix_valid = 1'b0;
        exp_a = '{17'd0, 17'd1610, 17'd0, 17'd1611, 17'd0, 17'd1612};
        exp_d = '{3'd7, 3'd2, 3'd7, 3'd2, 3'd7, 3'd2};
        k = 0;
        for (int j = 0; j < wa_q.size(); j++) begin
            if (wi_q[j] >= 2) begin
                if (k < 6) begin
                    chk("rr_addr", 32'(wa_q[j]), 32'(exp_a[k]));
                    chk("rr_data", 32'(wd_q[j]), 32'(exp_d[k]));
                end
                k++;
            end
        end
        chk("rr_count",   32'(k),       32'd6);
        chk("rr_done_at", 32'(done_at), 32'd7);
        tick();

        // Zero-width fill
        run_fill(9'd20, 8'd20, 9'd0, 8'd5, 3'd1, -1);
        chk("zero_writes",  32'(wa_q.size()), 32'd0);
        chk("zero_done_at", 32'(done_at),     32'd1);
        tick();

        // Start pulse and parameter change during a running 5x1 fill
        run_fill(9'd0, 8'd0, 9'd5, 8'd1, 3'd4, 2);
        chk("restart_count",   32'(wa_q.size()), 32'd5);
        for (int j = 0; j < 5 && j < wa_q.size(); j++)
            chk("restart_addr", 32'(wa_q[j]), 32'(j));
        chk("restart_done_at", 32'(done_at), 32'd6);
        bad = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (wr_en || fill_busy || fill_done) bad = 1'b1;
        end
        chk("restart_no_second_fill", 32'(bad), 32'd0);

        // Reset in the middle of a 10x10 fill
        fill_x0 = 9'd0; fill_y0 = 8'd0; fill_w = 9'd10; fill_h = 8'd10; fill_color = 3'd3;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        k = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (wr_en) k++;
        end
        chk("midrst_started", 32'(k > 0), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_wr_en", 32'(wr_en),     32'd0);
        chk("midrst_busy",  32'(fill_busy), 32'd0);
        chk("midrst_done",  32'(fill_done), 32'd0);
        bad = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (wr_en || fill_done || fill_busy) bad = 1'b1;
        end
        chk("midrst_quiet", 32'(bad), 32'd0);

        // Off-screen pixel
        pix_valid = 1'b1; pix_x = 9'd320; pix_y = 8'd0; pix_color = 3'd5;
        #1;
        chk("oob_ready", 32'(pix_ready), 32'd1);
        tick();
        pix_valid = 1'b0;
`ifdef FB_WR_BOUNDS_CHECK_EN
        chk("oob_no_write", 32'(wr_en),   32'd0);
        chk("oob_flag",     32'(oob_err), 32'd1);
        repeat (3) tick();
        chk("oob_sticky",   32'(oob_err), 32'd1);
`else
        chk("oob_write",      32'(wr_en),   32'd1);
        chk("oob_write_addr", 32'(wr_addr), 32'd320);
        chk("oob_flag_tied",  32'(oob_err), 32'd0);
        repeat (3) tick();
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("oob_cleared", 32'(oob_err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fb_write_ctrl.md
# fb_write_ctrl

Write-side controller for the 320x240, 3-bit-per-pixel VGA framebuffer. Two requesters share the framebuffer's single write port: a CPU pixel-store port (valid/ready) and an internal rectangle-fill engine, which the CPU configures and starts. The block drives the display module's `wr_en`/`wr_addr`/`wr_data` inputs, arbitrates round-robin, and computes linear addresses `y*320 + x` without a multiplier.

## Interface
- `H_RES`, 320, visible pixels per line
- `V_RES`, 240, visible lines
- `ADDR_W`, 17, framebuffer address width
- `COLOR_W`, 3, pixel colour width (RGB, 1 bit each)

Ports:
- `clock` in 1: single clock, the 50 MHz system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `pix_valid` in 1: CPU pixel write request.
- `pix_ready` out 1: pixel accepted this cycle (`pix_valid && pix_ready`).
- `pix_x` in 9: pixel column.
- `pix_y` in 8: pixel row.
- `pix_color` in `COLOR_W`: pixel colour.
- `fill_start` in 1: one-cycle pulse that starts a fill; ignored unless idle.
- `fill_x0` in 9, `fill_y0` in 8: rectangle origin.
- `fill_w` in 9, `fill_h` in 8: rectangle size.
- `fill_color` in `COLOR_W`: fill colour.
- `fill_busy` out 1: high from the cycle after an accepted start until `fill_done`.
- `fill_done` out 1: one-cycle completion pulse.
- `wr_en` out 1, `wr_addr` out `ADDR_W`, `wr_data` out `COLOR_W`: registered framebuffer write port.
- `oob_err` out 1: sticky out-of-bounds pixel flag, cleared by reset.

## Operation
- Fill FSM states:
  - `IDLE`: on `fill_start`, latch parameters and go to `SETUP`.
  - `SETUP`: clip the rectangle.
    - `xe = min(x0+w, H_RES)`, `ye = min(y0+h, V_RES)`; 10-bit sums, no wrap.
    - If `w==0`, `h==0`, `x0>=H_RES` or `y0>=V_RES`, go to `DONE` with zero writes.
    - Otherwise set `row_base = y0*320` (shift-add: `(y0<<8)+(y0<<6)`), `cx=x0`, `cy=y0`, and go to `FILL`.
  - `FILL`: each granted cycle issues `row_base+cx` and increments `cx`.
    - At `cx==xe-1`: set `cx=x0`, `cy++`, `row_base+=320`.
    - The grant covering `(xe-1, ye-1)` moves to `DONE`.
  - `DONE`: `fill_done=1` for one cycle, then `IDLE`.
- `fill_busy` = state is `SETUP`, `FILL` or `DONE`.
- Arbitration, only in `FILL` with `pix_valid` high:
  - Round-robin on a `last_grant` bit; the requester not granted last wins.
  - With no contention the sole requester is granted every cycle.
  - Outside `FILL`, `pix_ready = 1`.
- `pix_ready` is combinational from `pix_valid`, state and `last_grant`; it never depends on `pix_ready` itself.
- Pixel address is `pix_y*320 + pix_x`, computed by the same shift-add.
- A `fill_start` while busy is dropped; there is no queueing.
- Fill parameters are captured in `IDLE` only; later changes to them do not affect a running fill.

## Timing
- Reset values:
  - `wr_en=0`, `wr_addr=0`, `wr_data=0`, `fill_busy=0`, `fill_done=0`, `oob_err=0`.
  - State `IDLE`; `last_grant`=fill, so a pixel wins the first contention.
- Write latency: a grant in cycle K appears on `wr_*` in cycle K+1, for one cycle. `wr_en=0` in any cycle with no grant in the previous cycle.
- Fill sequence:
  - `fill_start` sampled at edge N.
  - `SETUP` during N+1.
  - First fill grant at N+2, first `wr_en` at N+3.
- `fill_done` coincides with the last fill write on `wr_*`.
- Uncontended fill of `n` pixels: `fill_done` at N+2+n. A zero-pixel fill gives `fill_done` at N+2.
- Reset mid-fill: next cycle `IDLE`, `wr_en=0`, no `fill_done`, no further writes.

## Configuration
- `FB_WR_BOUNDS_CHECK_EN` defined:
  - A pixel with `pix_x>=H_RES` or `pix_y>=V_RES` is still accepted (`pix_ready` handshake unchanged).
  - No write is issued for it, and `oob_err` sets and holds until reset.
  - It still consumes a grant slot, so round-robin stays unchanged.
- `FB_WR_BOUNDS_CHECK_EN` undefined:
  - No check; the computed address is written as-is, truncated to `ADDR_W`.
  - `oob_err` is tied to 0.
- Fill clipping is always present.

## Structure
- Shared package `fb_pkg` holds:
  - `H_RES`, `V_RES`, `ADDR_W`, `COLOR_W`.
  - The fill state enum (`IDLE`, `SETUP`, `FILL`, `DONE`).
  - A `fb_xy_to_addr` function (shift-add `y*320+x`).
- One sub-module, `fb_fill_engine`: FSM, counters, clipping, and a `req`/`gnt` pair toward the arbiter.
- Arbiter and output register stay in `fb_write_ctrl`.

## Test plan
- Reset, then pixel (x=5, y=2, colour 3'b101) → `pix_ready=1` same cycle; next cycle `wr_en=1`, `wr_addr=645`, `wr_data=5`; `oob_err=0`.
- Fill x0=318, y0=238, w=4, h=4, colour 3'b010 → 4 writes at 76478, 76479, 76798, 76799; `fill_done` with the fourth write; `fill_busy` low next cycle.
- Fill w=3, h=1 with `pix_valid` held high throughout (pixel at 0,0) → grants alternate pixel, fill, pixel, fill, pixel, fill; `fill_done` on the cycle of the third fill write.
- Fill with w=0 → no `wr_en`; `fill_done` 2 cycles after start. A `fill_start` during a running fill → ignored, pixel count unchanged.
- `reset` asserted mid-fill of a 10x10 rectangle → `wr_en=0` next cycle, `fill_done` never pulses, `fill_busy=0`.
- With `FB_WR_BOUNDS_CHECK_EN`, pixel (x=320, y=0) → accepted, no write, `oob_err=1` until reset. Without the macro → write at address 320.
